// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared iterative multiplier/divider and owns architectural HI/LO.
// Latency: accept -> start pulse 1 cycle; unit done -> HI/LO update, result_valid and busy low 1 cycle.
// Backpressure: requests are accepted only in IDLE; while busy, stall is raised combinationally to hold
//    the requester (op_valid) or an MFHI/MFLO reader (mf_req).
//
// Ports:
//    clock, reset          rising-edge clock, asynchronous active-low reset
//    op_valid/op_code      request from control unit (00 MULT, 01 DIV, 10 MTHI, 11 MTLO)
//    rs_data, rt_data      operands (rs_data is also the MTHI/MTLO source)
//    mf_req, flush         HI/LO read request, pipeline flush
//    mul_start, div_start  one-cycle start pulses; unit_a/unit_b latched operands
//    mul_*/div_*           unit done strobes and result halves
//    hi, lo                architectural HI/LO
//    busy, stall           run-state indicator, pipeline stall request
//    result_valid          pulse when MULT/DIV result lands in HI/LO
//    div_zero, timeout     sticky status of the last accepted operation
module muldiv_sequencer #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op_code,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        mf_req,
   input  logic        flush,
   output logic        mul_start,
   output logic        div_start,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   input  logic        mul_done,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   input  logic        div_done,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall,
   output logic        result_valid,
   output logic        div_zero,
   output logic        timeout
);

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
   typedef enum logic [1:0] {OP_MULT, OP_DIV, OP_MTHI, OP_MTLO} op_t;

   // Last run cycle before abort: the counter starts at 0 on the first run cycle.
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [31:0]       hi_nxt, lo_nxt, a_nxt, b_nxt;
   logic              mul_start_nxt, div_start_nxt, rv_nxt, dz_nxt, to_nxt;

   assign busy  = (state != IDLE);
   assign stall = busy & (op_valid | mf_req);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         hi           <= '0;
         lo           <= '0;
         unit_a       <= '0;
         unit_b       <= '0;
         mul_start    <= 1'b0;
         div_start    <= 1'b0;
         result_valid <= 1'b0;
         div_zero     <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         hi           <= hi_nxt;
         lo           <= lo_nxt;
         unit_a       <= a_nxt;
         unit_b       <= b_nxt;
         mul_start    <= mul_start_nxt;
         div_start    <= div_start_nxt;
         result_valid <= rv_nxt;
         div_zero     <= dz_nxt;
         timeout      <= to_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      hi_nxt        = hi;
      lo_nxt        = lo;
      a_nxt         = unit_a;
      b_nxt         = unit_b;
      mul_start_nxt = 1'b0;
      div_start_nxt = 1'b0;
      rv_nxt        = 1'b0;
      dz_nxt        = div_zero;
      to_nxt        = timeout;

      case (state)
         IDLE: begin
            // A flush in the same cycle drops the request entirely.
            if (op_valid && !flush) begin
               dz_nxt = 1'b0;
               to_nxt = 1'b0;
               case (op_t'(op_code))
                  OP_MULT: begin
                     a_nxt         = rs_data;
                     b_nxt         = rt_data;
                     mul_start_nxt = 1'b1;
                     cnt_nxt       = '0;
                     state_nxt     = MUL_RUN;
                  end
                  OP_DIV: begin
                     if (rt_data == 32'd0) begin
                        // Divide by zero never reaches the divider.
                        dz_nxt = 1'b1;
                     end else begin
                        a_nxt         = rs_data;
                        b_nxt         = rt_data;
                        div_start_nxt = 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = DIV_RUN;
                     end
                  end
                  OP_MTHI: hi_nxt = rs_data;
                  OP_MTLO: lo_nxt = rs_data;
                  default: ;
               endcase
            end
         end
         MUL_RUN, DIV_RUN: begin
            cnt_nxt = cnt + 1'b1;
            // Priority: flush, then the selected unit's done, then the timeout limit.
            if (flush) begin
               state_nxt = IDLE;
            end else if (state == MUL_RUN && mul_done) begin
               hi_nxt    = mul_hi;
               lo_nxt    = mul_lo;
               rv_nxt    = 1'b1;
               state_nxt = IDLE;
            end else if (state == DIV_RUN && div_done) begin
               hi_nxt    = div_hi;
               lo_nxt    = div_lo;
               rv_nxt    = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CNT_LIMIT) begin
               to_nxt    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench for muldiv_sequencer; unit done strobes driven by the bench.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [1:0]  op_code = 2'd0;
   logic [31:0] rs_data = '0, rt_data = '0;
   logic        mf_req = 1'b0, flush = 1'b0;
   logic        mul_start, div_start;
   logic [31:0] unit_a, unit_b;
   logic        mul_done = 1'b0, div_done = 1'b0;
   logic [31:0] mul_hi = '0, mul_lo = '0, div_hi = '0, div_lo = '0;
   logic [31:0] hi, lo;
   logic        busy, stall, result_valid, div_zero, timeout;

   int nchecks = 0;
   int nfail   = 0;

   muldiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .rs_data(rs_data), .rt_data(rt_data), .mf_req(mf_req), .flush(flush),
      .mul_start(mul_start), .div_start(div_start), .unit_a(unit_a), .unit_b(unit_b),
      .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
      .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
      .hi(hi), .lo(lo), .busy(busy), .stall(stall), .result_valid(result_valid),
      .div_zero(div_zero), .timeout(timeout)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present a request for exactly one accepting edge.
   task automatic do_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1; op_code = code; rs_data = a; rt_data = b;
      step();
      op_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      nchecks++;
      if ({hi, lo, unit_a, unit_b} !== 128'd0) begin
         nfail++; $display("FAIL reset_data: hi=%h lo=%h a=%h b=%h, required all 0", hi, lo, unit_a, unit_b);
      end
      nchecks++;
      if ({mul_start, div_start, busy, stall, result_valid, div_zero, timeout} !== 7'd0) begin
         nfail++; $display("FAIL reset_ctrl: got %b, required 0000000",
                           {mul_start, div_start, busy, stall, result_valid, div_zero, timeout});
      end
      #10 reset = 1'b1;
      step();
   endtask

   task automatic test_mult();
      int bad = 0;
      do_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD);
      nchecks++;
      if ({mul_start, div_start, busy} !== 3'b101) begin
         nfail++; $display("FAIL mult_start: mul/div/busy=%b, required 101", {mul_start, div_start, busy});
      end
      nchecks++;
      if ({unit_a, unit_b} !== {32'h0000_0007, 32'hFFFF_FFFD}) begin
         nfail++; $display("FAIL mult_operands: a=%h b=%h, required 00000007 fffffffd", unit_a, unit_b);
      end
      for (int i = 1; i < 33; i++) begin
         step();
         if (!busy || mul_start || div_start || result_valid) bad++;
      end
      nchecks++;
      if (bad != 0) begin
         nfail++; $display("FAIL mult_run: %0d bad run cycles, required 0", bad);
      end
      mul_done = 1'b1; mul_hi = 32'hFFFF_FFFF; mul_lo = 32'hFFFF_FFEB;
      step();
      mul_done = 1'b0;
      nchecks++;
      if ({hi, lo, result_valid, busy} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0}) begin
         nfail++; $display("FAIL mult_result: hi=%h lo=%h rv=%b busy=%b, required ffffffff ffffffeb 1 0",
                           hi, lo, result_valid, busy);
      end
      step();
      nchecks++;
      if (result_valid !== 1'b0) begin
         nfail++; $display("FAIL mult_rv_pulse: rv=%b, required 0", result_valid);
      end
   endtask

   task automatic test_div();
      do_op(2'b01, 32'd100, 32'd7);
      nchecks++;
      if ({mul_start, div_start, busy} !== 3'b011) begin
         nfail++; $display("FAIL div_start: mul/div/busy=%b, required 011", {mul_start, div_start, busy});
      end
      step();
      // Multiplier done while dividing must be ignored.
      mul_done = 1'b1; mul_hi = 32'h1111_1111; mul_lo = 32'h2222_2222;
      step();
      mul_done = 1'b0;
      nchecks++;
      if ({busy, result_valid, hi} !== {1'b1, 1'b0, 32'hFFFF_FFFF}) begin
         nfail++; $display("FAIL div_ignore_mul: busy=%b rv=%b hi=%h, required 1 0 ffffffff", busy, result_valid, hi);
      end
      step();
      div_done = 1'b1; div_hi = 32'd2; div_lo = 32'd14;
      step();
      div_done = 1'b0;
      nchecks++;
      if ({hi, lo, result_valid, busy} !== {32'd2, 32'd14, 1'b1, 1'b0}) begin
         nfail++; $display("FAIL div_result: hi=%h lo=%h rv=%b busy=%b, required 2 e 1 0", hi, lo, result_valid, busy);
      end
      do_op(2'b01, 32'd5, 32'd0);
      nchecks++;
      if ({div_start, mul_start, busy, div_zero, result_valid} !== 5'b00010) begin
         nfail++; $display("FAIL div_zero_flags: ds/ms/busy/dz/rv=%b, required 00010",
                           {div_start, mul_start, busy, div_zero, result_valid});
      end
      nchecks++;
      if ({hi, lo} !== {32'd2, 32'd14}) begin
         nfail++; $display("FAIL div_zero_hilo: hi=%h lo=%h, required 2 e", hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      op_valid = 1'b1; op_code = 2'b10; rs_data = 32'hDEAD_BEEF;
      #1;
      nchecks++;
      if (hi !== 32'd2) begin
         nfail++; $display("FAIL mthi_same_cycle: hi=%h, required 00000002", hi);
      end
      step();
      op_code = 2'b11; rs_data = 32'h1234_5678;
      nchecks++;
      if ({hi, lo, busy, result_valid, div_zero} !== {32'hDEAD_BEEF, 32'd14, 3'b000}) begin
         nfail++; $display("FAIL mthi: hi=%h lo=%h busy/rv/dz=%b, required deadbeef e 000",
                           hi, lo, {busy, result_valid, div_zero});
      end
      step();
      op_valid = 1'b0;
      nchecks++;
      if ({hi, lo, busy, result_valid} !== {32'hDEAD_BEEF, 32'h1234_5678, 2'b00}) begin
         nfail++; $display("FAIL mtlo: hi=%h lo=%h busy/rv=%b, required deadbeef 12345678 00",
                           hi, lo, {busy, result_valid});
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      do_op(2'b00, 32'd3, 32'd4);
      mf_req = 1'b1;
      // Second MULT held by the control unit for the whole run.
      op_valid = 1'b1; op_code = 2'b00; rs_data = 32'd5; rt_data = 32'd6;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (stall !== 1'b1 || mul_start !== (i == 0)) bad++;
         step();
      end
      nchecks++;
      if (bad != 0) begin
         nfail++; $display("FAIL stall_run: %0d bad run cycles, required 0", bad);
      end
      nchecks++;
      if (unit_a !== 32'd3) begin
         nfail++; $display("FAIL stall_hold_op: unit_a=%h, required 3", unit_a);
      end
      mul_done = 1'b1; mul_hi = 32'd0; mul_lo = 32'd12;
      step();
      mul_done = 1'b0;
      #1;
      nchecks++;
      if ({stall, busy, result_valid, lo} !== {3'b001, 32'd12}) begin
         nfail++; $display("FAIL stall_release: stall/busy/rv=%b lo=%h, required 001 c",
                           {stall, busy, result_valid}, lo);
      end
      step();
      op_valid = 1'b0; mf_req = 1'b0;
      nchecks++;
      if ({mul_start, busy, unit_a, unit_b} !== {2'b11, 32'd5, 32'd6}) begin
         nfail++; $display("FAIL second_accept: ms/busy=%b a=%h b=%h, required 11 5 6",
                           {mul_start, busy}, unit_a, unit_b);
      end
      step(); step();
      mul_done = 1'b1; mul_lo = 32'd30;
      step();
      mul_done = 1'b0;
      nchecks++;
      if ({lo, busy} !== {32'd30, 1'b0}) begin
         nfail++; $display("FAIL second_result: lo=%h busy=%b, required 1e 0", lo, busy);
      end
   endtask

   task automatic test_flush();
      do_op(2'b00, 32'd9, 32'd9);
      for (int i = 0; i < 5; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      nchecks++;
      if ({busy, result_valid, hi, lo} !== {2'b00, 32'd0, 32'd30}) begin
         nfail++; $display("FAIL flush_run: busy/rv=%b hi=%h lo=%h, required 00 0 1e", {busy, result_valid}, hi, lo);
      end
      for (int i = 0; i < 4; i++) step();
      mul_done = 1'b1; mul_hi = 32'hAAAA_AAAA; mul_lo = 32'hBBBB_BBBB;
      step();
      mul_done = 1'b0;
      nchecks++;
      if ({busy, result_valid, hi, lo} !== {2'b00, 32'd0, 32'd30}) begin
         nfail++; $display("FAIL late_done: busy/rv=%b hi=%h lo=%h, required 00 0 1e", {busy, result_valid}, hi, lo);
      end
      do_op(2'b00, 32'd2, 32'd2);
      step(); step();
      flush = 1'b1; mul_done = 1'b1;
      step();
      flush = 1'b0; mul_done = 1'b0;
      nchecks++;
      if ({busy, result_valid, hi, lo} !== {2'b00, 32'd0, 32'd30}) begin
         nfail++; $display("FAIL flush_vs_done: busy/rv=%b hi=%h lo=%h, required 00 0 1e", {busy, result_valid}, hi, lo);
      end
      flush = 1'b1;
      do_op(2'b10, 32'h1111_1111, 32'd0);
      flush = 1'b0;
      nchecks++;
      if ({busy, hi} !== {1'b0, 32'd0}) begin
         nfail++; $display("FAIL flush_idle: busy=%b hi=%h, required 0 0", busy, hi);
      end
   endtask

   task automatic test_timeout();
      do_op(2'b00, 32'd1, 32'd1);
      for (int i = 0; i < 39; i++) step();
      nchecks++;
      if ({busy, timeout} !== 2'b10) begin
         nfail++; $display("FAIL timeout_early: busy/to=%b after 39 cycles, required 10", {busy, timeout});
      end
      step();
      nchecks++;
      if ({busy, timeout, result_valid, hi, lo} !== {3'b010, 32'd0, 32'd30}) begin
         nfail++; $display("FAIL timeout_abort: busy/to/rv=%b hi=%h lo=%h, required 010 0 1e",
                           {busy, timeout, result_valid}, hi, lo);
      end
      // Done in the final allowed cycle beats the timeout.
      do_op(2'b00, 32'd1, 32'd1);
      nchecks++;
      if (timeout !== 1'b0) begin
         nfail++; $display("FAIL timeout_clear: to=%b, required 0", timeout);
      end
      for (int i = 0; i < 39; i++) step();
      mul_done = 1'b1; mul_hi = 32'd0; mul_lo = 32'd1;
      step();
      mul_done = 1'b0;
      nchecks++;
      if ({busy, timeout, result_valid, lo} !== {3'b001, 32'd1}) begin
         nfail++; $display("FAIL done_vs_timeout: busy/to/rv=%b lo=%h, required 001 1",
                           {busy, timeout, result_valid}, lo);
      end
   endtask

   task automatic test_async_reset();
      do_op(2'b00, 32'h5555_5555, 32'h6666_6666);
      step(); step();
      mf_req = 1'b1;
      #2 reset = 1'b0;
      #1;
      nchecks++;
      if ({hi, lo, unit_a, unit_b} !== 128'd0) begin
         nfail++; $display("FAIL async_reset_data: hi=%h lo=%h a=%h b=%h, required all 0", hi, lo, unit_a, unit_b);
      end
      nchecks++;
      if ({mul_start, div_start, busy, stall, result_valid, div_zero, timeout} !== 7'd0) begin
         nfail++; $display("FAIL async_reset_ctrl: got %b, required 0000000",
                           {mul_start, div_start, busy, stall, result_valid, div_zero, timeout});
      end
      mf_req = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_stall();
      test_flush();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

endmodule
